id_issue_stage: RTL and testbench
=================================

ID_ISSUE_STAGE -- requirements
Module: id_issue_stage

Interface
REQ-001 Parameter P_XLEN, default 32, datapath and PC width.
REQ-002 Parameter P_NREGS, default 32 (16 = RV32E), integer register count.
REQ-003 clk_i  in  1  clock, rising edge.
REQ-004 resetb_i  in  1  asynchronous, active-low reset.
REQ-005 clk_en_i  in  1  when low, no state changes and pfu_pull_o is 0.
REQ-006 flush_i  in  1  kill the not-yet-acked instruction (vectoring).
REQ-007 pfu_dav_i  in  1  fetch available.
REQ-008 pfu_pull_o  out  1  fetch consumed this cycle.
REQ-009 pfu_ins_i  in  32  fetched instruction.
REQ-010 pfu_ferr_i  in  1  fetch bus error.
REQ-011 pfu_pc_i  in  P_XLEN  fetch address.
REQ-012 ids_dav_o  out  1  issue register valid.
REQ-013 ids_ack_i  in  1  EX accepts the issue register.
REQ-014 ids_ins_o  out  32  issued instruction.
REQ-015 ids_pc_o  out  P_XLEN  issued PC.
REQ-016 ids_rs1_data_o, ids_rs2_data_o  out  P_XLEN each  source operands.
REQ-017 ids_regd_addr_o  out  5  destination; ids_regd_wr_o  out  1  writes destination.
REQ-018 ids_ferr_o  out  1  fetch error; ids_udef_o  out  1  undefined instruction.
REQ-019 wb_wr_i  in  1; wb_addr_i  in  5; wb_data_i  in  P_XLEN  write-back port.

Function
REQ-020 Pre-decode, opcode = ins[6:2]: rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM with funct3[2]=0 and funct3!=0; rs2 used by BRANCH, STORE, OP.
REQ-021 Destination written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM funct3!=0, only when rd!=0.
REQ-022 udef = ins[1:0]!=2'b11, or opcode outside RV32I set, or any used register address >= P_NREGS.
REQ-023 Scoreboard: one busy bit per register 1..P_NREGS-1; x0 never busy, always reads 0.
REQ-024 hazard = (rs1 used & busy[rs1]) | (rs2 used & busy[rs2]) | (rd written & busy[rd]).
REQ-025 pfu_pull_o = clk_en_i & pfu_dav_i & ~flush_i & ~hazard & (~ids_dav_o | ids_ack_i); udef/ferr instructions are pulled without hazard check.
REQ-026 On pull, issue register captures ins, pc, operands, rd, flags next edge; ids_dav_o=1; latency 1 cycle.
REQ-027 ids_dav_o clears on ack without pull; outputs hold stable while ids_dav_o=1 and ids_ack_i=0.
REQ-028 On pull of an instruction with regd_wr (not udef/ferr), busy[rd] sets.
REQ-029 wb_wr_i with wb_addr_i!=0 writes the register file and clears busy[wb_addr_i].
REQ-030 Same-cycle set and clear of one busy bit: set wins.
REQ-031 Bypass: operand read same cycle as write-back to that register uses wb_data_i.
REQ-032 udef/ferr instructions: ids_regd_wr_o=0, operands 0, no busy set.
REQ-033 flush_i (while clk_en_i): ids_dav_o clears next edge; busy bit set by the killed (unacked) instruction clears; acked instructions still retire via write-back.
REQ-034 flush_i and ids_ack_i same cycle: ack wins for that instruction, no busy clear.

Reset
REQ-035 Asynchronous reset: ids_dav_o=0, all data outputs 0, all busy bits 0, all registers 0.
REQ-036 First pull no earlier than first rising edge after resetb_i deasserts.

Verification
REQ-037 ADDI x1,x0,5 (0x00500093) at pc 0x100, ack tied 1 -> next cycle ids_dav_o=1, ids_regd_addr_o=1, ids_regd_wr_o=1, pull 1 cycle.
REQ-038 ADDI x1 then ADD x2,x1,x1 back-to-back -> ADD stalls (pull=0) until wb_wr_i x1=5; ADD issues with rs1=rs2=5 in that same cycle via bypass.
REQ-039 Hold ids_ack_i=0 three cycles with pfu_dav_i=1 -> pfu_pull_o=0, outputs constant; ack -> next pull same cycle.
REQ-040 P_NREGS=16, ADD x17,x1,x2 -> ids_udef_o=1, ids_regd_wr_o=0, no busy set; pfu_ferr_i=1 -> ids_ferr_o=1.
REQ-041 ADDI x3 issued, flush_i before ack -> ids_dav_o=0 next edge, busy[3]=0, subsequent ADD x4,x3,x0 issues without stall.
REQ-042 resetb_i low while ids_dav_o=1 and busy[1]=1 -> ids_dav_o=0, scoreboard clear immediately, x1 reads 0.

Source files
------------

// File: rtl/id_issue_stage.sv
// id_issue_stage: RV32I/E decode-and-issue stage.
//
// Pulls instructions from the prefetch unit, pre-decodes their register
// usage, reads operands from the integer register file (with write-back
// bypass) and holds them in a single issue register for the EX stage.
// A busy-bit scoreboard stalls instructions whose sources or destination
// are still owned by an earlier, not yet written-back instruction.
//
// Ports
//   clk_i, resetb_i   clock (rising edge), asynchronous active-low reset
//   clk_en_i          global enable; when low nothing changes, no pull
//   flush_i           kill the issue-register instruction if not acked
//   pfu_*             fetch side: dav/pull handshake, ins, ferr, pc
//   ids_*             issue register towards EX: dav/ack handshake,
//                     ins, pc, operands, destination, fetch/udef flags
//   wb_*              register file write-back port
//
// Handshakes: a transfer happens in any cycle where the producer's "dav"
// and the consumer's "pull"/"ack" are both high. Once ids_dav_o is high
// the issue register is held stable until ids_ack_i (or flush_i).
module id_issue_stage #(
  parameter int P_XLEN  = 32,
  parameter int P_NREGS = 32
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              flush_i,
  input  logic              pfu_dav_i,
  output logic              pfu_pull_o,
  input  logic [31:0]       pfu_ins_i,
  input  logic              pfu_ferr_i,
  input  logic [P_XLEN-1:0] pfu_pc_i,
  output logic              ids_dav_o,
  input  logic              ids_ack_i,
  output logic [31:0]       ids_ins_o,
  output logic [P_XLEN-1:0] ids_pc_o,
  output logic [P_XLEN-1:0] ids_rs1_data_o,
  output logic [P_XLEN-1:0] ids_rs2_data_o,
  output logic [4:0]        ids_regd_addr_o,
  output logic              ids_regd_wr_o,
  output logic              ids_ferr_o,
  output logic              ids_udef_o,
  input  logic              wb_wr_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [P_XLEN-1:0] wb_data_i
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  function automatic logic in_range(input logic [4:0] a);
    return ({27'd0, a} < P_NREGS);
  endfunction

  // Storage is always sized for 32 registers so 5-bit addresses index it
  // directly; entries at or above P_NREGS are never written and stay 0.
  logic [P_XLEN-1:0] regs [32];
  logic [31:0]       busy;

  logic [4:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opc = pfu_ins_i[6:2];
  assign f3  = pfu_ins_i[14:12];
  assign rs1 = pfu_ins_i[19:15];
  assign rs2 = pfu_ins_i[24:20];
  assign rd  = pfu_ins_i[11:7];

  logic opc_ok, rs1_used, rs2_used, rd_kind, regd_wr, udef, bad;

  always_comb begin
    opc_ok   = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_kind  = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: begin opc_ok = 1'b1; rd_kind = 1'b1; end
      OP_JALR, OP_LOAD, OP_IMM: begin
        opc_ok = 1'b1; rs1_used = 1'b1; rd_kind = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        opc_ok = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1;
      end
      OP_OP: begin
        opc_ok = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; rd_kind = 1'b1;
      end
      OP_MISC: opc_ok = 1'b1;
      // CSR register forms read rs1; every non-ECALL/EBREAK form writes rd.
      OP_SYSTEM: begin
        opc_ok   = 1'b1;
        rs1_used = !f3[2] && (f3 != 3'd0);
        rd_kind  = (f3 != 3'd0);
      end
      default: opc_ok = 1'b0;
    endcase
    regd_wr = rd_kind && (rd != 5'd0);
    udef = (pfu_ins_i[1:0] != 2'b11) || !opc_ok ||
           (rs1_used && !in_range(rs1)) ||
           (rs2_used && !in_range(rs2)) ||
           (regd_wr && !in_range(rd));
    bad = udef || pfu_ferr_i;
  end

  // Write-back: a retiring register is already free for this cycle's
  // hazard check and its value is forwarded to the operand read.
  logic              wb_hit;
  logic [31:0]       wb_clr;
  logic [31:0]       busy_eff;
  logic              hazard;
  logic [P_XLEN-1:0] rs1_val, rs2_val;

  assign wb_hit = wb_wr_i && (wb_addr_i != 5'd0) && in_range(wb_addr_i);

  always_comb begin
    wb_clr = '0;
    if (wb_hit) wb_clr[wb_addr_i] = 1'b1;
    busy_eff = busy & ~wb_clr;
    hazard = (rs1_used && busy_eff[rs1]) ||
             (rs2_used && busy_eff[rs2]) ||
             (regd_wr  && busy_eff[rd]);
    if (rs1 == 5'd0)                    rs1_val = '0;
    else if (wb_hit && wb_addr_i == rs1) rs1_val = wb_data_i;
    else                                 rs1_val = regs[rs1];
    if (rs2 == 5'd0)                    rs2_val = '0;
    else if (wb_hit && wb_addr_i == rs2) rs2_val = wb_data_i;
    else                                 rs2_val = regs[rs2];
  end

  // Faulty instructions bypass the hazard check: they never touch the
  // scoreboard or register file, so ordering against writers is moot.
  assign pfu_pull_o = clk_en_i && pfu_dav_i && !flush_i &&
                      (!ids_dav_o || ids_ack_i) && (bad || !hazard);

  // Scoreboard update. A flush releases the destination of an instruction
  // that EX never accepted; one accepted in the same cycle keeps its bit.
  logic [31:0] kill_clr, set_vec, busy_nxt;

  always_comb begin
    kill_clr = '0;
    set_vec  = '0;
    if (flush_i && ids_dav_o && !ids_ack_i && ids_regd_wr_o)
      kill_clr[ids_regd_addr_o] = 1'b1;
    if (pfu_pull_o && regd_wr && !bad)
      set_vec[rd] = 1'b1;
    busy_nxt = ((busy & ~wb_clr & ~kill_clr) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      busy            <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      ids_dav_o       <= 1'b0;
      ids_ins_o       <= '0;
      ids_pc_o        <= '0;
      ids_rs1_data_o  <= '0;
      ids_rs2_data_o  <= '0;
      ids_regd_addr_o <= '0;
      ids_regd_wr_o   <= 1'b0;
      ids_ferr_o      <= 1'b0;
      ids_udef_o      <= 1'b0;
    end else if (clk_en_i) begin
      busy <= busy_nxt;
      if (wb_hit) regs[wb_addr_i] <= wb_data_i;
      if (flush_i) begin
        ids_dav_o <= 1'b0;
      end else if (pfu_pull_o) begin
        ids_dav_o       <= 1'b1;
        ids_ins_o       <= pfu_ins_i;
        ids_pc_o        <= pfu_pc_i;
        ids_rs1_data_o  <= bad ? '0 : rs1_val;
        ids_rs2_data_o  <= bad ? '0 : rs2_val;
        ids_regd_addr_o <= rd;
        ids_regd_wr_o   <= regd_wr && !bad;
        ids_ferr_o      <= pfu_ferr_i;
        ids_udef_o      <= udef;
      end else if (ids_ack_i) begin
        ids_dav_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// tb_id_issue_stage: directed bench for id_issue_stage (P_NREGS = 16).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Each offered instruction pushes its expected issue
// record; the monitor pops and compares it the cycle after a pull.
module tb_id_issue_stage;

  localparam int W = 136;  // {ins, pc, rs1, rs2, rd, regd_wr, ferr, udef}

  logic        clk;
  logic        resetb;
  logic        clk_en;
  logic        flush;
  logic        pfu_dav;
  logic        pfu_pull;
  logic [31:0] pfu_ins;
  logic        pfu_ferr;
  logic [31:0] pfu_pc;
  logic        ids_dav;
  logic        ids_ack;
  logic [31:0] ids_ins;
  logic [31:0] ids_pc;
  logic [31:0] ids_rs1_data;
  logic [31:0] ids_rs2_data;
  logic [4:0]  ids_regd_addr;
  logic        ids_regd_wr;
  logic        ids_ferr;
  logic        ids_udef;
  logic        wb_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic pull_d = 1'b0;

  id_issue_stage #(.P_XLEN(32), .P_NREGS(16)) dut (
    .clk_i(clk), .resetb_i(resetb), .clk_en_i(clk_en), .flush_i(flush),
    .pfu_dav_i(pfu_dav), .pfu_pull_o(pfu_pull), .pfu_ins_i(pfu_ins),
    .pfu_ferr_i(pfu_ferr), .pfu_pc_i(pfu_pc),
    .ids_dav_o(ids_dav), .ids_ack_i(ids_ack), .ids_ins_o(ids_ins),
    .ids_pc_o(ids_pc), .ids_rs1_data_o(ids_rs1_data),
    .ids_rs2_data_o(ids_rs2_data), .ids_regd_addr_o(ids_regd_addr),
    .ids_regd_wr_o(ids_regd_wr), .ids_ferr_o(ids_ferr),
    .ids_udef_o(ids_udef),
    .wb_wr_i(wb_wr), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(
    input logic [31:0] ins, input logic [31:0] pc,
    input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd,
    input logic wr, input logic ferr, input logic udef);
    return {ins, pc, r1, r2, rd, wr, ferr, udef};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!resetb) begin
      pull_d = 1'b0;
    end else begin
      if (pull_d) begin
        chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("iss_dav",  32'(ids_dav),       32'd1);
          chk("iss_ins",  ids_ins,            e[135:104]);
          chk("iss_pc",   ids_pc,             e[103:72]);
          chk("iss_rs1",  ids_rs1_data,       e[71:40]);
          chk("iss_rs2",  ids_rs2_data,       e[39:8]);
          chk("iss_rd",   32'(ids_regd_addr), 32'(e[7:3]));
          chk("iss_wr",   32'(ids_regd_wr),   32'(e[2]));
          chk("iss_ferr", 32'(ids_ferr),      32'(e[1]));
          chk("iss_udef", 32'(ids_udef),      32'(e[0]));
        end
      end
      pull_d = pfu_pull;
    end
  end

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  task automatic offer(input logic [31:0] ins, input logic [31:0] pc,
                       input logic ferr, input logic exp_pull,
                       input logic exp_dav, input string tag);
    pfu_dav  = 1'b1;
    pfu_ins  = ins;
    pfu_pc   = pc;
    pfu_ferr = ferr;
    @(negedge clk);
    chk({tag, "_pull"}, 32'(pfu_pull), 32'(exp_pull));
    chk({tag, "_dav"},  32'(ids_dav),  32'(exp_dav));
    @(posedge clk); #1;
    wb_wr    = 1'b0;
    pfu_ferr = 1'b0;
  endtask

  task automatic idle(input logic exp_dav, input string tag);
    pfu_dav = 1'b0;
    @(negedge clk);
    chk({tag, "_pull"}, 32'(pfu_pull), 32'd0);
    chk({tag, "_dav"},  32'(ids_dav),  32'(exp_dav));
    @(posedge clk); #1;
    wb_wr = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_wr   = 1'b1;
    wb_addr = a;
    wb_data = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetb = 1'b1; clk_en = 1'b1; flush = 1'b0; pfu_dav = 1'b0;
    pfu_ins = '0; pfu_ferr = 1'b0; pfu_pc = '0; ids_ack = 1'b1;
    wb_wr = 1'b0; wb_addr = '0; wb_data = '0;
    #1 resetb = 1'b0;
    #1;
    chk("rst_dav",  32'(ids_dav),       32'd0);
    chk("rst_ins",  ids_ins,            32'd0);
    chk("rst_pc",   ids_pc,             32'd0);
    chk("rst_rs1",  ids_rs1_data,       32'd0);
    chk("rst_wr",   32'(ids_regd_wr),   32'd0);
    chk("rst_rd",   32'(ids_regd_addr), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetb = 1'b1;
    @(posedge clk); #1;

    // ADDI x1,x0,5 then dependent ADD x2,x1,x1: stall until x1 writes back.
    exp_q.push_back(rec(32'h0050_0093, 32'h100, 0, 0, 5'd1, 1, 0, 0));
    offer(32'h0050_0093, 32'h100, 0, 1, 0, "addi_x1");
    chk("addi_rd_addr", 32'(ids_regd_addr), 32'd1);
    chk("addi_rd_wr",   32'(ids_regd_wr),   32'd1);
    exp_q.push_back(rec(32'h0010_8133, 32'h104, 5, 5, 5'd2, 1, 0, 0));
    offer(32'h0010_8133, 32'h104, 0, 0, 1, "add_stall0");
    offer(32'h0010_8133, 32'h104, 0, 0, 0, "add_stall1");
    wb(5'd1, 32'd5);
    offer(32'h0010_8133, 32'h104, 0, 1, 0, "add_bypass");
    wb(5'd2, 32'h22);
    idle(1, "add_held");

    // Back-pressure: ack low for three cycles freezes the issue register.
    ids_ack = 1'b0;
    exp_q.push_back(rec(32'h0070_0193, 32'h108, 0, 0, 5'd3, 1, 0, 0));
    offer(32'h0070_0193, 32'h108, 0, 1, 0, "addi_x3");
    exp_q.push_back(rec(32'h0090_0213, 32'h10c, 0, 0, 5'd4, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      offer(32'h0090_0213, 32'h10c, 0, 0, 1, "bp_hold");
      chk("bp_ins", ids_ins, 32'h0070_0193);
      chk("bp_pc",  ids_pc,  32'h108);
    end
    ids_ack = 1'b1;
    offer(32'h0090_0213, 32'h10c, 0, 1, 1, "bp_release");
    wb(5'd3, 32'd7);
    idle(1, "x4_held");
    wb(5'd4, 32'd9);
    idle(0, "x4_gone");

    // Undefined and fetch-error instructions; neither claims its rd.
    exp_q.push_back(rec(32'h0020_88b3, 32'h200, 0, 0, 5'd17, 0, 0, 1));
    offer(32'h0020_88b3, 32'h200, 0, 1, 0, "udef_x17");
    exp_q.push_back(rec(32'h0010_0290, 32'h204, 0, 0, 5'd5, 0, 0, 1));
    offer(32'h0010_0290, 32'h204, 0, 1, 1, "udef_lowbits");
    exp_q.push_back(rec(32'h0002_8313, 32'h208, 0, 0, 5'd6, 1, 0, 0));
    offer(32'h0002_8313, 32'h208, 0, 1, 1, "after_udef");
    exp_q.push_back(rec(32'h0010_0393, 32'h20c, 0, 0, 5'd7, 0, 1, 0));
    offer(32'h0010_0393, 32'h20c, 1, 1, 1, "ferr");
    exp_q.push_back(rec(32'h0073_8433, 32'h210, 0, 0, 5'd8, 1, 0, 0));
    offer(32'h0073_8433, 32'h210, 0, 1, 1, "after_ferr");
    wb(5'd6, 32'h66);
    idle(1, "x8_held");
    wb(5'd8, 32'h88);
    idle(0, "x8_gone");

    // Clock enable low: no pull, no state change.
    clk_en = 1'b0;
    offer(32'h0010_0493, 32'h214, 0, 0, 0, "cke_off0");
    offer(32'h0010_0493, 32'h214, 0, 0, 0, "cke_off1");
    clk_en = 1'b1;
    exp_q.push_back(rec(32'h0010_0493, 32'h214, 0, 5, 5'd9, 1, 0, 0));
    offer(32'h0010_0493, 32'h214, 0, 1, 0, "cke_on");
    wb(5'd9, 32'd1);
    idle(1, "x9_held");

    // Flush before ack releases x3; dependent ADD x4,x3,x0 issues at once.
    ids_ack = 1'b0;
    exp_q.push_back(rec(32'h0070_0193, 32'h300, 0, 0, 5'd3, 1, 0, 0));
    offer(32'h0070_0193, 32'h300, 0, 1, 0, "fl_addi_x3");
    flush = 1'b1;
    idle(1, "fl_cycle");
    flush = 1'b0;
    ids_ack = 1'b1;
    exp_q.push_back(rec(32'h0001_8233, 32'h304, 7, 0, 5'd4, 1, 0, 0));
    offer(32'h0001_8233, 32'h304, 0, 1, 0, "fl_add_x4");
    wb(5'd4, 32'h44);
    idle(1, "x4b_held");

    // Flush together with ack: x5 stays busy until its write-back.
    ids_ack = 1'b0;
    exp_q.push_back(rec(32'h0010_0293, 32'h308, 0, 5, 5'd5, 1, 0, 0));
    offer(32'h0010_0293, 32'h308, 0, 1, 0, "flack_x5");
    flush = 1'b1;
    ids_ack = 1'b1;
    idle(1, "flack_cycle");
    flush = 1'b0;
    exp_q.push_back(rec(32'h0002_8333, 32'h30c, 32'h55, 0, 5'd6, 1, 0, 0));
    offer(32'h0002_8333, 32'h30c, 0, 0, 0, "flack_stall");
    wb(5'd5, 32'h55);
    offer(32'h0002_8333, 32'h30c, 0, 1, 0, "flack_issue");
    wb(5'd6, 32'h66);
    idle(1, "x6_held");

    // Reset with a pending issue and busy x1 clears everything at once.
    ids_ack = 1'b0;
    exp_q.push_back(rec(32'h0050_0093, 32'h400, 0, 32'h55, 5'd1, 1, 0, 0));
    offer(32'h0050_0093, 32'h400, 0, 1, 0, "pre_rst_x1");
    idle(1, "pre_rst_hold");
    resetb = 1'b0;
    #1;
    chk("arst_dav", 32'(ids_dav),     32'd0);
    chk("arst_ins", ids_ins,          32'd0);
    chk("arst_rs2", ids_rs2_data,     32'd0);
    chk("arst_wr",  32'(ids_regd_wr), 32'd0);
    #2 resetb = 1'b1;
    @(posedge clk); #1;
    ids_ack = 1'b1;
    exp_q.push_back(rec(32'h0010_8133, 32'h404, 0, 0, 5'd2, 1, 0, 0));
    offer(32'h0010_8133, 32'h404, 0, 1, 0, "post_rst_add");
    idle(1, "post_rst_held");
    idle(0, "post_rst_gone");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
